reg_write_arb: RTL

REG_WRITE_ARB -- requirements
Module: reg_write_arb

---
 rtl/reg_write_arb.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/reg_write_arb.sv
// ---------------------------------------------------------------------------
// reg_write_arb
// Arbitrates register-file write requests from three sources (ALU, load
// unit, control ops) onto a single registered write port, and keeps a
// scoreboard of registers that are waiting for load data.
//
// Ports
//   CLK, ResetN                    clock, asynchronous active-low reset
//   {Alu,Mem,Ctl}Valid/Reg/Data    write requests (held until Ready)
//   {Alu,Mem,Ctl}Ready             combinational one-hot grant
//   LdIssue, LdReg                 announce an outstanding load to LdReg
//   WriteReg, WReg, WriteValue     registered write port, one cycle after grant
//   Busy                           per-register "awaiting load data" flags
//   LdErr                          sticky: load issued to an already-busy reg
// ---------------------------------------------------------------------------
module reg_write_arb #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic             CLK,
    input  logic             ResetN,
    input  logic             AluValid,
    input  logic [D-1:0]     AluReg,
    input  logic [W-1:0]     AluData,
    input  logic             MemValid,
    input  logic [D-1:0]     MemReg,
    input  logic [W-1:0]     MemData,
    input  logic             CtlValid,
    input  logic [D-1:0]     CtlReg,
    input  logic [W-1:0]     CtlData,
    output logic             AluReady,
    output logic             MemReady,
    output logic             CtlReady,
    input  logic             LdIssue,
    input  logic [D-1:0]     LdReg,
    output logic             WriteReg,
    output logic [D-1:0]     WReg,
    output logic [W-1:0]     WriteValue,
    output logic [(1<<D)-1:0] Busy,
    output logic             LdErr
);

    localparam int N = 1 << D;

    // Requester indices used by the round-robin pointer.
    localparam logic [1:0] IDX_ALU = 2'd0;
    localparam logic [1:0] IDX_MEM = 2'd1;
    localparam logic [1:0] IDX_CTL = 2'd2;

    logic [1:0]   r_ptr;       // highest-priority requester this cycle
    logic         r_wr_en;
    logic [D-1:0] r_wreg;
    logic [W-1:0] r_wdata;
    logic [N-1:0] r_busy;
    logic         r_lderr;

    logic [2:0]   w_elig;      // bit0 ALU, bit1 Mem, bit2 Ctl
    logic [2:0]   w_gnt;
    logic         w_xfer;
    logic         w_mem_xfer;
    logic [1:0]   w_gnt_idx;
    logic [D-1:0] w_sel_reg;
    logic [W-1:0] w_sel_data;
    logic [N-1:0] w_busy_nxt;
    logic         w_err_set;

    // Round-robin pick: first eligible requester at or after ptr, one-hot.
    function automatic logic [2:0] rr_pick(input logic [2:0] elig, input logic [1:0] ptr);
        logic [2:0] g;
        g = 3'b000;
        case (ptr)
            2'd1: begin
                if (elig[1]) g = 3'b010;
                else if (elig[2]) g = 3'b100;
                else if (elig[0]) g = 3'b001;
                else g = 3'b000;
            end
            2'd2: begin
                if (elig[2]) g = 3'b100;
                else if (elig[0]) g = 3'b001;
                else if (elig[1]) g = 3'b010;
                else g = 3'b000;
            end
            default: begin
                if (elig[0]) g = 3'b001;
                else if (elig[1]) g = 3'b010;
                else if (elig[2]) g = 3'b100;
                else g = 3'b000;
            end
        endcase
        return g;
    endfunction

    // Eligibility (WAW block on busy registers) and grant selection.
    always_comb begin
        w_elig[0] = AluValid & ~r_busy[AluReg];
        w_elig[1] = MemValid;
        w_elig[2] = CtlValid & ~r_busy[CtlReg];
        w_gnt     = rr_pick(w_elig, r_ptr);
        w_xfer    = |w_gnt;
        w_mem_xfer = w_gnt[1];
        case (w_gnt)
            3'b010: begin
                w_gnt_idx  = IDX_MEM;
                w_sel_reg  = MemReg;
                w_sel_data = MemData;
            end
            3'b100: begin
                w_gnt_idx  = IDX_CTL;
                w_sel_reg  = CtlReg;
                w_sel_data = CtlData;
            end
            default: begin
                w_gnt_idx  = IDX_ALU;
                w_sel_reg  = AluReg;
                w_sel_data = AluData;
            end
        endcase
    end

    // Scoreboard next state: a Mem write clears its register, then a new
    // load re-marks it, so a same-cycle load to the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        w_err_set  = 1'b0;
        if (w_mem_xfer) begin
            w_busy_nxt[MemReg] = 1'b0;
        end else begin
            w_busy_nxt = r_busy;
        end
        if (LdIssue) begin
            if (r_busy[LdReg] && !(w_mem_xfer && (MemReg == LdReg))) begin
                w_err_set = 1'b1;
            end else begin
                w_busy_nxt[LdReg] = 1'b1;
            end
        end else begin
            w_err_set = 1'b0;
        end
    end

    // Arbitration pointer, write port and scoreboard registers.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            r_ptr   <= IDX_ALU;
            r_wr_en <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
            r_busy  <= '0;
            r_lderr <= 1'b0;
        end else begin
            r_wr_en <= w_xfer;
            if (w_xfer) begin
                r_wreg  <= w_sel_reg;
                r_wdata <= w_sel_data;
                r_ptr   <= (w_gnt_idx == IDX_CTL) ? IDX_ALU : (w_gnt_idx + 2'd1);
            end else begin
                r_wreg  <= r_wreg;
                r_wdata <= r_wdata;
                r_ptr   <= r_ptr;
            end
            r_busy  <= w_busy_nxt;
            r_lderr <= r_lderr | w_err_set;
        end
    end

    // Grants are combinational; masked so nothing is granted during reset.
    assign AluReady   = w_gnt[0] & ResetN;
    assign MemReady   = w_gnt[1] & ResetN;
    assign CtlReady   = w_gnt[2] & ResetN;
    assign WriteReg   = r_wr_en;
    assign WReg       = r_wreg;
    assign WriteValue = r_wdata;
    assign Busy       = r_busy;
    assign LdErr      = r_lderr;

endmodule
